// File: rtl/alu_op_runner.sv
// alu_op_runner
//
// Sequential front-end for an 8-bit combinational ALU. Commands arrive over a
// valid/ready handshake, are registered onto the ALU inputs, and after a
// programmable settle time the ALU result is captured into a small result
// FIFO. Results leave the FIFO in command order, each tagged with a 4-bit
// sequence number.
//
// Parameters:
//   SETTLE_CYCLES  clock edges between driving the ALU and sampling alu_out (1..15)
//   FIFO_DEPTH     result FIFO entries (power of two, >= 2)
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_a, cmd_b         8-bit operands
//   cmd_mode             3-bit ALU mode
//   alu_a, alu_b         registered drive to the ALU operand inputs
//   alu_mode             registered drive to the ALU mode input
//   alu_out              ALU result, combinational from alu_a/alu_b/alu_mode
//   res_valid/res_ready  result handshake (FIFO head)
//   res_data             captured ALU result at the FIFO head
//   res_mode             mode that produced res_data
//   res_tag              sequence tag of the command that produced res_data
//   busy                 a command is in flight

module alu_op_runner #(
  parameter int SETTLE_CYCLES = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [2:0] cmd_mode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_mode,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [2:0] res_mode,
  output logic [3:0] res_tag,
  output logic       busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] DEPTH_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    SETTLE
  } state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic [3:0] tag_ctr;
  logic [3:0] tag_cur;

  logic [14:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic accept;
  logic push;
  logic pop;

  // Ready depends only on registered state so there is no path from cmd_valid.
  assign cmd_ready = (state == IDLE) && (count < DEPTH_FULL);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = (state == SETTLE) && (cnt == 4'd0);
  assign pop       = res_valid && res_ready;
  assign busy      = (state == SETTLE);

  // Result outputs come straight from FIFO storage and the registered count.
  assign res_valid = (count != '0);
  assign res_data  = mem[rd_ptr][14:7];
  assign res_mode  = mem[rd_ptr][6:4];
  assign res_tag   = mem[rd_ptr][3:0];

  // State and settle-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: an accepted command loads the settle counter, which
  // counts down to zero; the capture edge always returns to IDLE, giving the
  // mandatory idle cycle between commands.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SETTLE;
          cnt_next   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // ALU drive registers and tags. The ALU inputs change only on accept, so
  // they are stable for the whole settle window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a    <= 8'd0;
      alu_b    <= 8'd0;
      alu_mode <= 3'd0;
      tag_ctr  <= 4'd0;
      tag_cur  <= 4'd0;
    end else if (accept) begin
      alu_a    <= cmd_a;
      alu_b    <= cmd_b;
      alu_mode <= cmd_mode;
      tag_cur  <= tag_ctr;
      tag_ctr  <= tag_ctr + 4'd1;
    end
  end

  // Result FIFO. Storage is cleared on reset so the head reads zero when empty
  // after reset. A push can never hit a full FIFO because cmd_ready is
  // withheld while full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {alu_out, alu_mode, tag_cur};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_runner.sv
// tb_alu_op_runner
//
// Bench for alu_op_runner with a stub XOR ALU. One instance uses default
// parameters and is tracked every cycle by a transaction-level model (queue of
// expected results, in-flight countdown). A second instance with
// SETTLE_CYCLES=3 is exercised with directed checks only.

module tb_alu_op_runner;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;

  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [2:0] cmd_mode;
  logic [7:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_mode;
  logic       res_valid, res_ready;
  logic [7:0] res_data;
  logic [2:0] res_mode;
  logic [3:0] res_tag;
  logic       busy;

  logic       s3_cmd_valid;
  logic       s3_cmd_ready;
  logic [7:0] s3_cmd_a, s3_cmd_b;
  logic [2:0] s3_cmd_mode;
  logic [7:0] s3_alu_a, s3_alu_b, s3_alu_out;
  logic [2:0] s3_alu_mode;
  logic       s3_res_valid, s3_res_ready;
  logic [7:0] s3_res_data;
  logic [2:0] s3_res_mode;
  logic [3:0] s3_res_tag;
  logic       s3_busy;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] mode;
    logic [3:0] tag;
  } res_t;

  res_t got[$];

  // Model state
  res_t       mq[$];
  logic       m_inflight = 1'b0;
  int         m_left     = 0;
  logic [7:0] m_a        = 8'd0;
  logic [7:0] m_b        = 8'd0;
  logic [2:0] m_mode     = 3'd0;
  logic [3:0] m_tag      = 4'd0;
  logic [3:0] m_tag_ctr  = 4'd0;

  assign alu_out    = alu_a ^ alu_b;
  assign s3_alu_out = s3_alu_a ^ s3_alu_b;

  alu_op_runner #(.SETTLE_CYCLES(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_mode(cmd_mode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_mode(res_mode), .res_tag(res_tag),
    .busy(busy)
  );

  alu_op_runner #(.SETTLE_CYCLES(3), .FIFO_DEPTH(DEPTH)) dut_s3 (
    .clk(clk), .reset(reset),
    .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready),
    .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b), .cmd_mode(s3_cmd_mode),
    .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_mode(s3_alu_mode), .alu_out(s3_alu_out),
    .res_valid(s3_res_valid), .res_ready(s3_res_ready),
    .res_data(s3_res_data), .res_mode(s3_res_mode), .res_tag(s3_res_tag),
    .busy(s3_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    tests_run++;
    tests_failed++;
    $display("[TB] FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  // Behavioural model: one command in flight at a time, result appears after
  // SETTLE_CYCLES edges, results queue in order up to DEPTH entries.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_inflight = 1'b0;
        m_left     = 0;
        m_a        = 8'd0;
        m_b        = 8'd0;
        m_mode     = 3'd0;
        m_tag      = 4'd0;
        m_tag_ctr  = 4'd0;
      end else begin
        logic do_pop, do_push, do_accept;
        do_pop    = (mq.size() > 0) && res_ready;
        do_push   = m_inflight && (m_left == 0);
        do_accept = !m_inflight && (mq.size() < DEPTH) && cmd_valid;
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back('{data: m_a ^ m_b, mode: m_mode, tag: m_tag});
        if (m_inflight) begin
          if (m_left == 0) m_inflight = 1'b0;
          else m_left--;
        end else if (do_accept) begin
          m_a        = cmd_a;
          m_b        = cmd_b;
          m_mode     = cmd_mode;
          m_tag      = m_tag_ctr;
          m_tag_ctr  = m_tag_ctr + 4'd1;
          m_left     = 0;
          m_inflight = 1'b1;
        end
      end
    end
  end

  // Compare the default instance against the model on every falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("cmd_ready", cmd_ready, (!m_inflight && mq.size() < DEPTH));
      checkOutput("busy", busy, m_inflight);
      checkOutput("alu_a", alu_a, m_a);
      checkOutput("alu_b", alu_b, m_b);
      checkOutput("alu_mode", alu_mode, m_mode);
      checkOutput("res_valid", res_valid, (mq.size() > 0));
      if (mq.size() > 0) begin
        checkOutput("res_data", res_data, mq[0].data);
        checkOutput("res_mode", res_mode, mq[0].mode);
        checkOutput("res_tag", res_tag, mq[0].tag);
      end
    end
  end

  // Collect popped results for the directed literal checks.
  initial begin
    forever begin
      @(posedge clk);
      if (!reset && res_valid && res_ready)
        got.push_back('{data: res_data, mode: res_mode, tag: res_tag});
    end
  end

  task automatic resetDut();
    @(negedge clk);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    got.delete();
  endtask

  // Hold cmd_valid with the current operands until the block accepts.
  task automatic waitAccept();
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) reportTimeout("cmd_accept");
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [2:0] mode);
    @(negedge clk);
    cmd_a     = a;
    cmd_b     = b;
    cmd_mode  = mode;
    cmd_valid = 1'b1;
    waitAccept();
  endtask

  task automatic waitResults(input int n);
    int k;
    k = 0;
    while (got.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (got.size() < n) reportTimeout("results");
  endtask

  initial begin
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_a        = 8'd0;
    cmd_b        = 8'd0;
    cmd_mode     = 3'd0;
    res_ready    = 1'b0;
    s3_cmd_valid = 1'b0;
    s3_cmd_a     = 8'd0;
    s3_cmd_b     = 8'd0;
    s3_cmd_mode  = 3'd0;
    s3_res_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_b", alu_b, 0);
    checkOutput("rst_alu_mode", alu_mode, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_data", res_data, 0);
    checkOutput("rst_res_mode", res_mode, 0);
    checkOutput("rst_res_tag", res_tag, 0);
    checkOutput("rst_busy", busy, 0);

    // Single op
    res_ready = 1'b1;
    applyStimulus(8'hAF, 8'h41, 3'd0);
    checkOutput("single_busy_e0", busy, 1);
    checkOutput("single_valid_e0", res_valid, 0);
    @(posedge clk); #1;
    checkOutput("single_valid_e1", res_valid, 1);
    checkOutput("single_data", res_data, 8'hEE);
    checkOutput("single_mode", res_mode, 0);
    checkOutput("single_tag", res_tag, 0);
    checkOutput("single_busy_e1", busy, 0);
    @(posedge clk); #1;
    checkOutput("single_popped", res_valid, 0);

    // Back-to-back
    resetDut();
    res_ready = 1'b1;
    applyStimulus(8'hA0, 8'h91, 3'd1);
    applyStimulus(8'hAA, 8'hF0, 3'd4);
    waitResults(2);
    if (got.size() >= 2) begin
      checkOutput("b2b_data0", got[0].data, 8'h31);
      checkOutput("b2b_mode0", got[0].mode, 1);
      checkOutput("b2b_tag0", got[0].tag, 0);
      checkOutput("b2b_data1", got[1].data, 8'h5A);
      checkOutput("b2b_mode1", got[1].mode, 4);
      checkOutput("b2b_tag1", got[1].tag, 1);
    end

    // Backpressure: four results fill the FIFO, fifth waits
    resetDut();
    res_ready = 1'b0;
    for (int k = 0; k < 4; k++) applyStimulus(8'(k + 1), 8'hFF, 3'd2);
    @(negedge clk);
    cmd_a     = 8'h05;
    cmd_b     = 8'hFF;
    cmd_mode  = 3'd2;
    cmd_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("bp_ready_low", cmd_ready, 0);
    end
    checkOutput("bp_head_tag", res_tag, 0);
    res_ready = 1'b1;
    waitAccept();
    waitResults(5);
    if (got.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        checkOutput("bp_tag", got[k].tag, k);
        checkOutput("bp_data", got[k].data, 8'hFF ^ 8'(k + 1));
      end
    end

    // Tag wrap
    resetDut();
    res_ready = 1'b1;
    for (int k = 0; k < 17; k++) applyStimulus(8'(k), 8'h3C, 3'(k));
    waitResults(17);
    if (got.size() >= 17) begin
      for (int k = 0; k < 17; k++) checkOutput("wrap_tag", got[k].tag, k % 16);
      checkOutput("wrap_tag15", got[15].tag, 15);
      checkOutput("wrap_tag16", got[16].tag, 0);
      checkOutput("wrap_data16", got[16].data, 8'h2C);
    end

    // SETTLE_CYCLES=3 instance
    @(negedge clk);
    s3_cmd_a     = 8'hFF;
    s3_cmd_b     = 8'h0F;
    s3_cmd_mode  = 3'd3;
    s3_cmd_valid = 1'b1;
    checkOutput("s3_ready", s3_cmd_ready, 1);
    @(posedge clk); #1;
    s3_cmd_valid = 1'b0;
    checkOutput("s3_busy", s3_busy, 1);
    checkOutput("s3_ready_settle", s3_cmd_ready, 0);
    for (int k = 1; k <= 2; k++) begin
      checkOutput("s3_valid_early", s3_res_valid, 0);
      checkOutput("s3_alu_a", s3_alu_a, 8'hFF);
      checkOutput("s3_alu_b", s3_alu_b, 8'h0F);
      @(posedge clk); #1;
    end
    checkOutput("s3_valid_early", s3_res_valid, 0);
    checkOutput("s3_alu_a", s3_alu_a, 8'hFF);
    @(posedge clk); #1;
    checkOutput("s3_valid", s3_res_valid, 1);
    checkOutput("s3_data", s3_res_data, 8'hF0);
    checkOutput("s3_mode", s3_res_mode, 3);
    checkOutput("s3_busy_done", s3_busy, 0);

    // Reset mid-op with two results queued
    resetDut();
    res_ready = 1'b0;
    applyStimulus(8'h11, 8'h22, 3'd3);
    applyStimulus(8'h33, 8'h44, 3'd5);
    applyStimulus(8'h77, 8'h01, 3'd6);
    checkOutput("mid_busy_before", busy, 1);
    checkOutput("mid_valid_before", res_valid, 1);
    #1 reset = 1'b1;
    #1;
    checkOutput("mid_res_valid", res_valid, 0);
    checkOutput("mid_busy", busy, 0);
    checkOutput("mid_alu_a", alu_a, 0);
    checkOutput("mid_alu_b", alu_b, 0);
    checkOutput("mid_alu_mode", alu_mode, 0);
    #1 reset = 1'b0;
    got.delete();
    res_ready = 1'b1;
    applyStimulus(8'h55, 8'h66, 3'd7);
    waitResults(1);
    if (got.size() >= 1) begin
      checkOutput("post_rst_tag", got[0].tag, 0);
      checkOutput("post_rst_data", got[0].data, 8'h33);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_op_runner.md
# alu_op_runner

Sequential front-end for the 8-bit combinational ALU. It accepts operand/mode commands over a valid/ready handshake and drives them onto the ALU's A/B/MODE inputs. After a programmable settle time it captures the ALU's OUT and returns the results, in order and tagged, through a small result FIFO with its own valid/ready handshake. It sits between a command source (sequencer or CPU datapath) and an ALU instance, replacing direct combinational drive of the ALU.

## Interface
- SETTLE_CYCLES, 1: clock edges between driving the ALU inputs and sampling ALU_OUT; legal range 1..15.
- FIFO_DEPTH, 4: result FIFO entries; power of two, at least 2.

- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high; clears all state immediately.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  block can accept a command this cycle.
- CMD_A  in  8  operand A.
- CMD_B  in  8  operand B.
- CMD_MODE  in  3  ALU mode.
- ALU_A  out  8  registered drive to ALU input A.
- ALU_B  out  8  registered drive to ALU input B.
- ALU_MODE  out  3  registered drive to ALU input MODE.
- ALU_OUT  in  8  ALU result, treated as combinational from ALU_A/ALU_B/ALU_MODE.
- RES_VALID  out  1  FIFO head holds a result.
- RES_READY  in  1  consumer takes the head.
- RES_DATA  out  8  captured ALU_OUT at the FIFO head.
- RES_MODE  out  3  mode that produced RES_DATA.
- RES_TAG  out  4  sequence tag of the command that produced RES_DATA.
- BUSY  out  1  a command is in flight, i.e. the FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE: waits for a command.
  - SETTLE: waits for the ALU result, using a 4-bit down-counter.
- CMD_READY = (state==IDLE) && (fifo_count < FIFO_DEPTH), computed combinationally from registered state only.
- Accept happens when CMD_VALID && CMD_READY at a rising edge. On accept:
  - ALU_A/ALU_B/ALU_MODE load CMD_A/CMD_B/CMD_MODE.
  - The in-flight tag is set to tag_ctr, and tag_ctr increments.
  - The settle counter loads SETTLE_CYCLES-1, and the state moves to SETTLE.
- In SETTLE, at each edge:
  - If the counter is 0: push {ALU_OUT, ALU_MODE, tag} into the FIFO and return to IDLE.
  - Otherwise: decrement the counter.
- ALU_A/ALU_B/ALU_MODE hold their last value until the next accept. They are never changed while in SETTLE.
- tag_ctr is 4 bits and wraps from 15 to 0 with no stall.
- Only one command is in flight at a time. Results leave the FIFO strictly in command order.
- A pop happens when RES_VALID && RES_READY at an edge.
- A push and a pop in the same edge leave fifo_count unchanged, and both the data and the pointers advance correctly.
- Full FIFO: CMD_READY is held low, so a push can never overflow. A push while full is impossible by construction.
- Empty FIFO: RES_VALID=0. RES_DATA/RES_MODE/RES_TAG are meaningful only while RES_VALID=1.
- RESET, at any time including mid-SETTLE:
  - state=IDLE and the in-flight command is discarded.
  - The FIFO is emptied and tag_ctr=0.
  - All outputs take their reset values.

## Timing
- Reset values:
  - CMD_READY=1 (once RESET deasserts).
  - ALU_A=0, ALU_B=0, ALU_MODE=0.
  - RES_VALID=0, RES_DATA=0, RES_MODE=0, RES_TAG=0.
  - BUSY=0.
- Latency: accept at edge E0 gives a FIFO push at edge E0+SETTLE_CYCLES. If the FIFO was empty, RES_VALID rises right after that edge.
- Throughput: one command per SETTLE_CYCLES+1 cycles. There is a mandatory IDLE cycle after each capture.
- CMD_READY is low in every cycle the FSM is in SETTLE.
- BUSY equals (state==SETTLE).
- RES_VALID/RES_DATA/RES_MODE/RES_TAG are registered or come straight from FIFO storage, with no combinational path from RES_READY.
- A pop and a push at the same edge with fifo_count=1 keep RES_VALID=1 and present the new entry.

## Test plan
The bench uses a stub ALU with ALU_OUT = ALU_A ^ ALU_B. Parameters are default unless noted.
- Single op: A=8'hAF, B=8'h41, MODE=0, RES_READY=1 → accepted at E0; RES_VALID=1 after E1 with RES_DATA=8'hEE, RES_MODE=0, RES_TAG=0; BUSY high for exactly 1 cycle.
- Back-to-back with RES_READY=1: commands (8'hA0, 8'h91, 1) then (8'hAA, 8'hF0, 4) → results 8'h31 (tag 0) then 8'h5A (tag 1); CMD_READY=0 in each SETTLE cycle.
- Backpressure: RES_READY=0, five commands issued → the first four are accepted with tags 0..3; CMD_READY stays 0 after the fourth capture. Then RES_READY=1 → results pop in order 0..3 and the fifth command is accepted.
- Tag wrap: 17 commands with RES_READY=1 → tags 0..15, then 0.
- SETTLE_CYCLES=3: single op (8'hFF, 8'h0F) → RES_VALID rises exactly 3 edges after accept with RES_DATA=8'hF0; ALU_A/ALU_B stable throughout.
- Reset mid-op: assert RESET during SETTLE with 2 results queued → asynchronously RES_VALID=0, BUSY=0, ALU_A=0, ALU_B=0, ALU_MODE=0; after release, the next result has tag 0.
